// File: rtl/ppu_fx_pkg.sv
// Shared fixed-point format helpers and default Fx formats for the posit/quire datapath.
package ppu_fx_pkg;

    localparam int FX_M_IN_DEFAULT  = 4;
    localparam int FX_B_IN_DEFAULT  = 15;
    localparam int FX_M_OUT_DEFAULT = 8;
    localparam int FX_B_OUT_DEFAULT = 31;

    // Fraction bits of Fx<M,B>; B excludes the sign bit.
    function automatic int fx_frac_bits(input int m, input int b);
        return b - m;
    endfunction

endpackage

// File: rtl/fixed_widen_comb.sv
// Pure combinational widening Fx<M_IN,B_IN> -> Fx<M_OUT,B_OUT>: sign-extend then align the binary point.
module fixed_widen_comb
    import ppu_fx_pkg::*;
#(
    parameter int FX_M_IN  = FX_M_IN_DEFAULT,
    parameter int FX_B_IN  = FX_B_IN_DEFAULT,
    parameter int FX_M_OUT = FX_M_OUT_DEFAULT,
    parameter int FX_B_OUT = FX_B_OUT_DEFAULT
) (
    input  logic [FX_B_IN:0]  fixed_i,
    output logic [FX_B_OUT:0] fixed_o
);

    localparam int SHIFT_RAW = fx_frac_bits(FX_M_OUT, FX_B_OUT) - fx_frac_bits(FX_M_IN, FX_B_IN);
    localparam int SHIFT     = (SHIFT_RAW < 0) ? 0 : SHIFT_RAW;

    logic [FX_B_OUT:0] ext;

    genvar gi;
    generate
        for (gi = 0; gi <= FX_B_OUT; gi++) begin : g_ext
            if (gi <= FX_B_IN) begin : g_copy
                assign ext[gi] = fixed_i[gi];
            end else begin : g_sign
                assign ext[gi] = fixed_i[FX_B_IN];
            end
        end
    endgenerate

    // Extra integer bits are covered by the sign extension, so the shift can never overflow.
    assign fixed_o = ext << SHIFT;

endmodule

// File: rtl/fixed_widen_pipe.sv
// Two-stage valid/ready pipeline widening fixed-point words; optional handshake counter under PPU_FX_WIDEN_STATS_EN.
module fixed_widen_pipe
    import ppu_fx_pkg::*;
#(
    parameter int FX_M_IN  = FX_M_IN_DEFAULT,
    parameter int FX_B_IN  = FX_B_IN_DEFAULT,
    parameter int FX_M_OUT = FX_M_OUT_DEFAULT,
    parameter int FX_B_OUT = FX_B_OUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [FX_B_IN:0]  fixed_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [FX_B_OUT:0] fixed_o
`ifdef PPU_FX_WIDEN_STATS_EN
    ,
    input  logic              clr_cnt_i,
    output logic [15:0]       conv_cnt_o
`endif
);

    generate
        if (FX_M_OUT < FX_M_IN) begin : g_chk_int
            $error("fixed_widen_pipe: FX_M_OUT must be >= FX_M_IN");
        end
        if (fx_frac_bits(FX_M_OUT, FX_B_OUT) < fx_frac_bits(FX_M_IN, FX_B_IN)) begin : g_chk_frac
            $error("fixed_widen_pipe: output fraction bits must be >= input fraction bits");
        end
        if (FX_M_IN < 1 || FX_B_IN < 1 || FX_M_OUT < 1 || FX_B_OUT < 1) begin : g_chk_pos
            $error("fixed_widen_pipe: all format parameters must be >= 1");
        end
    endgenerate

    logic              a_valid_reg;
    logic [FX_B_IN:0]  a_data_reg;
    logic              b_valid_reg;
    logic [FX_B_OUT:0] b_data_reg;
    logic [FX_B_OUT:0] widened;
    logic              b_adv;

    fixed_widen_comb #(
        .FX_M_IN (FX_M_IN),
        .FX_B_IN (FX_B_IN),
        .FX_M_OUT(FX_M_OUT),
        .FX_B_OUT(FX_B_OUT)
    ) u_widen (
        .fixed_i(a_data_reg),
        .fixed_o(widened)
    );

    // ready_o follows ready_i combinationally so a full pipe can still shift every cycle.
    assign b_adv   = !b_valid_reg || ready_i;
    assign ready_o = !a_valid_reg || b_adv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_valid_reg <= 1'b0;
            a_data_reg  <= '0;
            b_valid_reg <= 1'b0;
            b_data_reg  <= '0;
        end else begin
            if (b_adv) begin
                b_valid_reg <= a_valid_reg;
                if (a_valid_reg) begin
                    b_data_reg <= widened;
                end
            end
            if (ready_o) begin
                a_valid_reg <= valid_i;
                if (valid_i) begin
                    a_data_reg <= fixed_i;
                end
            end
        end
    end

    assign valid_o = b_valid_reg;
    assign fixed_o = b_data_reg;

`ifdef PPU_FX_WIDEN_STATS_EN
    logic [15:0] conv_cnt_reg;

    // Clear wins over a same-cycle handshake; the count wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            conv_cnt_reg <= '0;
        end else if (b_valid_reg && ready_i) begin
            conv_cnt_reg <= conv_cnt_reg + 16'd1;
        end
    end

    assign conv_cnt_o = conv_cnt_reg;
`endif

endmodule

// File: tb/tb_fixed_widen_pipe.sv
// Scoreboard testbench for fixed_widen_pipe (default 4/15 -> 8/31); define PPU_FX_WIDEN_STATS_EN to cover the counter.
module tb_fixed_widen_pipe;

    localparam int FX_M_IN  = 4;
    localparam int FX_B_IN  = 15;
    localparam int FX_M_OUT = 8;
    localparam int FX_B_OUT = 31;
    localparam int SH = (FX_B_OUT - FX_M_OUT) - (FX_B_IN - FX_M_IN);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [FX_B_IN:0]  fixed_i = '0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [FX_B_OUT:0] fixed_o;
`ifdef PPU_FX_WIDEN_STATS_EN
    logic              clr_cnt_i = 1'b0;
    logic [15:0]       conv_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    logic [FX_B_OUT:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    fixed_widen_pipe #(
        .FX_M_IN (FX_M_IN),
        .FX_B_IN (FX_B_IN),
        .FX_M_OUT(FX_M_OUT),
        .FX_B_OUT(FX_B_OUT)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .fixed_i(fixed_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .fixed_o(fixed_o)
`ifdef PPU_FX_WIDEN_STATS_EN
        ,
        .clr_cnt_i (clr_cnt_i),
        .conv_cnt_o(conv_cnt_o)
`endif
    );

    // Reference: value scaled by 2^SH in a wide signed integer.
    function automatic logic [FX_B_OUT:0] model(input logic [FX_B_IN:0] x);
        longint v;
        v = longint'($signed(x));
        v = v * (longint'(1) << SH);
        return v[FX_B_OUT:0];
    endfunction

    // Handshakes are judged mid-cycle, so they describe what the next rising edge will do.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && ready_i) begin
                logic [FX_B_OUT:0] exp_v;
                checks++;
                out_cnt++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got=%h required=none", fixed_o);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (fixed_o !== exp_v) begin
                        errors++;
                        $display("FAIL sb_data got=%h required=%h", fixed_o, exp_v);
                    end else begin
                        $display("out  %h ok", fixed_o);
                    end
                end
            end
            if (valid_i && ready_o) begin
                sb_q.push_back(model(fixed_i));
                $display("in   %h", fixed_i);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || fixed_o !== '0) begin
            errors++;
            $display("FAIL reset got v=%b r=%b d=%h required v=0 r=1 d=0", valid_o, ready_o, fixed_o);
        end
`ifdef PPU_FX_WIDEN_STATS_EN
        checks++;
        if (conv_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d required=0", conv_cnt_o);
        end
`endif
    endtask

    task automatic test_single();
        bit ok;
        ready_i = 1'b1;
        valid_i = 1'b1;
        fixed_i = 16'h0800;
        step();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early got valid_o=%b required=0", valid_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || fixed_o !== 32'h0080_0000) begin
            errors++;
            $display("FAIL single got v=%b d=%h required v=1 d=00800000", valid_o, fixed_o);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain got=timeout required=empty");
        end
    endtask

    task automatic test_signs();
        logic [15:0] ins  [3] = '{16'hF800, 16'h8000, 16'h7FFF};
        logic [31:0] outs [3] = '{32'hFF80_0000, 32'hF800_0000, 32'h07FF_F000};
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            fixed_i = ins[i];
            step();
            valid_i = 1'b0;
            step();
            checks++;
            if (valid_o !== 1'b1 || fixed_o !== outs[i]) begin
                errors++;
                $display("FAIL sign_%0d got v=%b d=%h required v=1 d=%h", i, valid_o, fixed_o, outs[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int base;
        base = out_cnt;
        ready_i = 1'b0;
        valid_i = 1'b1;
        fixed_i = 16'h0001;
        step();
        fixed_i = 16'h0002;
        step();
        fixed_i = 16'h0003;
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || fixed_o !== 32'h0000_1000) begin
            errors++;
            $display("FAIL bp_full got r=%b v=%b d=%h required r=0 v=1 d=00001000", ready_o, valid_o, fixed_o);
        end
        step();
        step();
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || fixed_o !== 32'h0000_1000) begin
            errors++;
            $display("FAIL bp_hold got r=%b v=%b d=%h required r=0 v=1 d=00001000", ready_o, valid_o, fixed_o);
        end
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        drain(ok);
        checks++;
        if (!ok || out_cnt - base != 3) begin
            errors++;
            $display("FAIL bp_count got=%0d required=3", out_cnt - base);
        end
    endtask

    task automatic test_throughput();
        bit ok;
        int base;
        base = out_cnt;
        ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            valid_i = 1'b1;
            fixed_i = 16'($urandom);
            step();
            checks++;
            if (i > 0 && valid_o !== 1'b1) begin
                errors++;
                $display("FAIL tput_bubble cycle=%0d got valid_o=%b required=1", i, valid_o);
            end
        end
        valid_i = 1'b0;
        drain(ok);
        checks++;
        if (!ok || out_cnt - base != 100) begin
            errors++;
            $display("FAIL tput_count got=%0d required=100", out_cnt - base);
        end
    endtask

    task automatic test_midreset();
        int base;
        ready_i = 1'b0;
        valid_i = 1'b1;
        fixed_i = 16'h1234;
        step();
        fixed_i = 16'h4321;
        step();
        valid_i = 1'b0;
        rst_i = 1'b1;
        ready_i = 1'b1;
        base = out_cnt;
        step();
        rst_i = 1'b0;
        sb_q.delete();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || fixed_o !== '0) begin
            errors++;
            $display("FAIL midrst got v=%b r=%b d=%h required v=0 r=1 d=0", valid_o, ready_o, fixed_o);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_cnt != base || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_emit got=%0d required=0", out_cnt - base);
        end
    endtask

`ifdef PPU_FX_WIDEN_STATS_EN
    task automatic test_stats();
        bit ok;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            fixed_i = 16'(i * 7 + 1);
            step();
        end
        valid_i = 1'b0;
        drain(ok);
        step();
        checks++;
        if (conv_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL cnt_5 got=%0d required=5", conv_cnt_o);
        end
        valid_i = 1'b1;
        fixed_i = 16'h0010;
        step();
        valid_i = 1'b0;
        step();
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        checks++;
        if (conv_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr got=%0d required=0", conv_cnt_o);
        end
        drain(ok);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_signs();
        test_backpressure();
        test_throughput();
        test_midreset();
`ifdef PPU_FX_WIDEN_STATS_EN
        test_stats();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_widen_pipe.md
Name: fixed_widen_pipe

Overview:
- Streaming fixed-point re-format unit for the widening direction: Fx<FX_M_IN, FX_B_IN> -> Fx<FX_M_OUT, FX_B_OUT>, where the output has at least as many integer bits and at least as many fraction bits as the input.
- Sits between posit-decode/fixed producers and wide accumulators (e.g. the quire-side datapath).
- Two-stage valid/ready pipeline with full throughput under no backpressure.

Parameters:
- FX_M_IN, 4: input integer bits, excluding sign.
- FX_B_IN, 15: input total bits, excluding sign. Input word is 1+FX_B_IN bits; FX_B_IN-FX_M_IN fraction bits.
- FX_M_OUT, 8: output integer bits, excluding sign.
- FX_B_OUT, 31: output total bits, excluding sign. Output word is 1+FX_B_OUT bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input word valid.
- ready_o  out  1  block can accept an input word.
- fixed_i  in  1+FX_B_IN  two's-complement input, MSB is sign.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts the output word.
- fixed_o  out  1+FX_B_OUT  two's-complement widened output.
- Only with PPU_FX_WIDEN_STATS_EN:
  - clr_cnt_i  in  1  synchronous clear of the counter.
  - conv_cnt_o  out  16  output handshake count.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Elaboration checks:
  - $error if FX_M_OUT < FX_M_IN.
  - $error if (FX_B_OUT-FX_M_OUT) < (FX_B_IN-FX_M_IN).
  - $error if any parameter is < 1.
- Arithmetic (combinational, between stage A and stage B):
  - Let FI = FX_B_IN-FX_M_IN and FO = FX_B_OUT-FX_M_OUT.
  - fixed_o = sign_extend(fixed_i, 1+FX_B_OUT) << (FO-FI).
  - Exact: no rounding, no overflow possible.
  - The represented value is preserved bit-exactly, including the most-negative input.
- Stage A: regs a_valid, a_data.
- Stage B: regs b_valid, b_data. These drive valid_o and fixed_o.
- b_adv = !b_valid || ready_i.
  - When b_adv: b_valid <= a_valid; b_data <= widen(a_data) if a_valid.
- ready_o = !a_valid || b_adv. This path is combinational from ready_i, which is intended.
  - When ready_o: a_valid <= valid_i; a_data <= fixed_i if valid_i.
- Latency: a word accepted at edge N (valid_i && ready_o) is presented on fixed_o with valid_o=1 after edge N+1.
- Throughput: 1 word/cycle while ready_i=1.
- Backpressure (ready_i=0 with valid_o=1):
  - fixed_o and valid_o hold stable.
  - Stage A can still fill once; ready_o then drops.
  - Max 2 words in flight.
- Drain: when ready_i=1 and valid_i=0, words exit in order. No word is dropped or duplicated.
- Simultaneous events: accept and emit in the same cycle is allowed (pipeline shift).
- Reset:
  - a_valid=0, b_valid=0, so valid_o=0 and ready_o=1.
  - fixed_o=0; data regs are cleared.
  - Reset mid-stream discards in-flight words. No output handshake occurs in the reset cycle.
- valid_o must not depend combinationally on valid_i.

Optional Feature:
- Macro: PPU_FX_WIDEN_STATS_EN.
- With the macro defined:
  - conv_cnt_o increments on every output handshake (valid_o && ready_i) and wraps 0xFFFF->0.
  - clr_cnt_i clears it to 0 next cycle. clr has priority over a same-cycle increment.
  - Reset clears it.
- Without the macro: the counter and both ports are absent, and the datapath is unchanged.

Decomposition:
- Shared package ppu_fx_pkg:
  - function fx_frac_bits(M,B) = B-M.
  - localparams for default Fx formats.
- Natural sub-module: fixed_widen_comb, the pure combinational sign-extend-and-shift, instantiated between stages.
- The pipeline/handshake logic stays in fixed_widen_pipe.

Test Plan (defaults 4/15 -> 8/31):
- Reset: assert rst_i 2 cycles -> valid_o=0, ready_o=1, fixed_o=0.
- Single word, ready_i=1: fixed_i=0x0800 (1.0) at edge N -> fixed_o=0x0080_0000 with valid_o=1 after edge N+1.
- Sign cases:
  - 0xF800 (-1.0) -> 0xFF80_0000.
  - 0x8000 (-16.0) -> 0xF800_0000.
  - 0x7FFF -> 0x07FF_F000.
- Backpressure: stream 0x0001,0x0002,0x0003 with ready_i=0 -> ready_o drops after 2 accepts, fixed_o holds 0x0000_1000. Then ready_i=1 -> outputs 0x1000, 0x2000, 0x3000 in order, none lost.
- Full throughput: 100 random words with ready_i=1 -> 100 outputs, each matching the scoreboard.
- Mid-stream reset and stats:
  - Assert rst_i with 2 words in flight -> valid_o=0 next cycle, nothing emitted.
  - With PPU_FX_WIDEN_STATS_EN: 5 handshakes -> conv_cnt_o=5. Assert clr_cnt_i -> 0.
